// File: rtl/ila_generator_ml_if.sv
// Handshake and config bundle between the SYNC~/CGS controller
// and the JESD204B ILA generator.
interface ila_generator_ml_if #(
   parameter int LANES = 4
);
   logic                 i_seq_start;
   logic                 i_abort;
   logic [4:0]           i_no_frame_de_assertion;
   logic [7:0]           i_ila_mf;
   logic [7:0]           i_DID;
   logic [3:0]           i_BID;
   logic [4:0]           i_LID_base;
   logic                 i_SCR;
   logic [4:0]           i_L;
   logic [7:0]           i_M;
   logic [4:0]           i_N;
   logic [1:0]           i_CS;
   logic [4:0]           i_N_ap;
   logic [7:0]           i_F;
   logic [4:0]           i_K;
   logic [4:0]           i_S;
   logic                 i_HD;
   logic [4:0]           i_CF;
   logic [8*LANES-1:0]   o_data;
   logic [LANES-1:0]     o_k;
   logic                 o_busy;
   logic                 o_seq_end;
   logic                 o_cfg_err;

   modport master (
      output i_seq_start, i_abort, i_no_frame_de_assertion, i_ila_mf,
      output i_DID, i_BID, i_LID_base, i_SCR, i_L, i_M, i_N, i_CS,
      output i_N_ap, i_F, i_K, i_S, i_HD, i_CF,
      input  o_data, o_k, o_busy, o_seq_end, o_cfg_err
   );

   modport slave (
      input  i_seq_start, i_abort, i_no_frame_de_assertion, i_ila_mf,
      input  i_DID, i_BID, i_LID_base, i_SCR, i_L, i_M, i_N, i_CS,
      input  i_N_ap, i_F, i_K, i_S, i_HD, i_CF,
      output o_data, o_k, o_busy, o_seq_end, o_cfg_err
   );
endinterface

// File: rtl/ila_generator_ml.sv
// JESD204B multi-lane ILA generator: /R/../A/ multiframes with /Q/ and
// link config in multiframe 1; K28.5 whenever no ILA is running.
module ila_generator_ml #(
   parameter int LANES = 4
) (
   input  logic clk,
   input  logic rst,
   ila_generator_ml_if.slave bus
);

   typedef enum logic {IDLE, GEN_ILA} state_t;

   state_t      state_q, state_d;
   logic [7:0]  oct_q, oct_d;
   logic [4:0]  frm_q, frm_d;
   logic [7:0]  mf_q, mf_d;
   logic [7:0]  r_q, r_d;
   logic        cfg_err_q, cfg_err_d;

   logic [7:0]  did_c, m_c, f_c, mfn_c;
   logic [3:0]  bid_c, adjcnt_c;
   logic [4:0]  lidb_c, l_c, n_c, nap_c, k_c, s_c, cf_c;
   logic [1:0]  cs_c;
   logic        scr_c, hd_c, adjdir_c, phadj_c;

   logic [5:0]  kd_in;
   logic [6:0]  dly;
   logic [13:0] fk_in;
   logic [3:0]  adjcnt_in;
   logic        adjdir_in, phadj_in;
   logic        start_ok, cfg_ok;

   logic        last_oct, last_frm, seq_end;
   logic [8:0]  fd_c;
   logic [12:0] p;
   logic [3:0]  c;
   logic        is_r, is_a, is_q, is_cfg;
   logic [7:0]  fchk_base;
   logic [4:0]  lid;
   logic [7:0]  oct;
   logic        kk;

   // Phase adjust: advance when the de-assertion frame is in the first half
   always_comb begin
      kd_in = {1'b0, bus.i_K} + 6'd1;
      dly = {1'b0, kd_in} - {2'b0, bus.i_no_frame_de_assertion};
      fk_in = ({6'b0, bus.i_F} + 14'd1) * {8'b0, kd_in};
      adjcnt_in = '0;
      adjdir_in = 1'b0;
      phadj_in = 1'b0;
      if (bus.i_no_frame_de_assertion != 5'd0) begin
         phadj_in = 1'b1;
         if ({2'b0, bus.i_no_frame_de_assertion} <= dly) begin
            adjcnt_in = (bus.i_no_frame_de_assertion > 5'd15) ?
                        4'd15 : bus.i_no_frame_de_assertion[3:0];
         end else begin
            adjdir_in = 1'b1;
            adjcnt_in = (dly > 7'd15) ? 4'd15 : dly[3:0];
         end
      end
   end

   assign start_ok = bus.i_seq_start && !bus.i_abort;
   assign cfg_ok   = fk_in >= 14'd17;

   assign last_oct = oct_q == f_c;
   assign last_frm = frm_q == k_c;
   assign seq_end  = (state_q == GEN_ILA) && last_oct && last_frm
                     && (mf_q == mfn_c);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         oct_q     <= '0;
         frm_q     <= '0;
         mf_q      <= '0;
         r_q       <= '0;
         cfg_err_q <= 1'b0;
         did_c     <= '0;
         bid_c     <= '0;
         lidb_c    <= '0;
         scr_c     <= 1'b0;
         l_c       <= '0;
         m_c       <= '0;
         n_c       <= '0;
         cs_c      <= '0;
         nap_c     <= '0;
         f_c       <= '0;
         k_c       <= '0;
         s_c       <= '0;
         hd_c      <= 1'b0;
         cf_c      <= '0;
         mfn_c     <= '0;
         adjcnt_c  <= '0;
         adjdir_c  <= 1'b0;
         phadj_c   <= 1'b0;
      end else begin
         state_q   <= state_d;
         oct_q     <= oct_d;
         frm_q     <= frm_d;
         mf_q      <= mf_d;
         r_q       <= r_d;
         cfg_err_q <= cfg_err_d;
         if (state_q == IDLE && start_ok && cfg_ok) begin
            did_c    <= bus.i_DID;
            bid_c    <= bus.i_BID;
            lidb_c   <= bus.i_LID_base;
            scr_c    <= bus.i_SCR;
            l_c      <= bus.i_L;
            m_c      <= bus.i_M;
            n_c      <= bus.i_N;
            cs_c     <= bus.i_CS;
            nap_c    <= bus.i_N_ap;
            f_c      <= bus.i_F;
            k_c      <= bus.i_K;
            s_c      <= bus.i_S;
            hd_c     <= bus.i_HD;
            cf_c     <= bus.i_CF;
            mfn_c    <= bus.i_ila_mf;
            adjcnt_c <= adjcnt_in;
            adjdir_c <= adjdir_in;
            phadj_c  <= phadj_in;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      oct_d     = oct_q;
      frm_d     = frm_q;
      mf_d      = mf_q;
      r_d       = r_q;
      cfg_err_d = cfg_err_q;
      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               if (cfg_ok) begin
                  state_d   = GEN_ILA;
                  cfg_err_d = 1'b0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         GEN_ILA: begin
            if (bus.i_abort || seq_end) begin
               state_d = IDLE;
               oct_d   = '0;
               frm_d   = '0;
               mf_d    = '0;
               r_d     = '0;
            end else begin
               r_d = r_q + 8'd1;
               if (last_oct) begin
                  oct_d = '0;
                  if (last_frm) begin
                     frm_d = '0;
                     mf_d  = mf_q + 8'd1;
                  end else begin
                     frm_d = frm_q + 5'd1;
                  end
               end else begin
                  oct_d = oct_q + 8'd1;
               end
            end
         end
      endcase
   end

   assign fd_c   = {1'b0, f_c} + 9'd1;
   assign p      = {8'b0, frm_q} * {4'b0, fd_c} + {5'b0, oct_q};
   assign c      = p[3:0] - 4'd2;
   assign is_r   = (oct_q == 8'd0) && (frm_q == 5'd0);
   assign is_a   = last_oct && last_frm;
   assign is_q   = (mf_q == 8'd1) && (p == 13'd1);
   assign is_cfg = (mf_q == 8'd1) && (p >= 13'd2) && (p <= 13'd15);

   // FCHK minus the lane-specific LID term; SUBCLASSV and JESDV are both 1
   assign fchk_base = did_c + {4'b0, bid_c} + {4'b0, adjcnt_c}
                    + {7'b0, phadj_c} + {7'b0, adjdir_c} + {3'b0, l_c}
                    + {7'b0, scr_c} + f_c + {3'b0, k_c} + m_c
                    + {3'b0, n_c} + {6'b0, cs_c} + {3'b0, nap_c}
                    + {3'b0, s_c} + {3'b0, cf_c} + {7'b0, hd_c} + 8'd2;

   function automatic logic [7:0] cfg_octet(input logic [3:0] ci,
                                            input logic [4:0] li);
      logic [7:0] v;
      v = 8'h00;
      unique case (ci)
         4'd0:    v = did_c;
         4'd1:    v = {adjcnt_c, bid_c};
         4'd2:    v = {1'b0, adjdir_c, phadj_c, li};
         4'd3:    v = {scr_c, 2'b00, l_c};
         4'd4:    v = f_c;
         4'd5:    v = {3'b000, k_c};
         4'd6:    v = m_c;
         4'd7:    v = {cs_c, 1'b0, n_c};
         4'd8:    v = {3'd1, nap_c};
         4'd9:    v = {3'd1, s_c};
         4'd10:   v = {hd_c, 2'b00, cf_c};
         4'd13:   v = fchk_base + {3'b0, li};
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   always_comb begin
      bus.o_data = '0;
      bus.o_k    = '0;
      lid = '0;
      oct = 8'hBC;
      kk  = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         lid = lidb_c + 5'(i);
         oct = 8'hBC;
         kk  = 1'b1;
         if (state_q == GEN_ILA) begin
            unique case (1'b1)
               is_r:    oct = 8'h1C;
               is_a:    oct = 8'h7C;
               is_q:    oct = 8'h9C;
               is_cfg: begin
                  oct = cfg_octet(c, lid);
                  kk  = 1'b0;
               end
               default: begin
                  oct = r_q;
                  kk  = 1'b0;
               end
            endcase
         end
         bus.o_data[8*i +: 8] = oct;
         bus.o_k[i] = kk;
      end
   end

   assign bus.o_busy    = state_q == GEN_ILA;
   assign bus.o_seq_end = seq_end;
   assign bus.o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_ila_generator_ml.sv
// Randomised and directed bench for ila_generator_ml against a
// frame-arithmetic reference model of the ILA octet stream.
module tb_ila_generator_ml;

   localparam int LANES = 4;

   typedef struct {
      int did, bid, lidb, scr, l, m, n, cs, nap;
      int f, k, s, hd, cf, mf, nfd;
   } cfg_t;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   ila_generator_ml_if #(.LANES(LANES)) bus ();

   ila_generator_ml #(.LANES(LANES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic apply(input cfg_t c);
      bus.i_DID = 8'(c.did);
      bus.i_BID = 4'(c.bid);
      bus.i_LID_base = 5'(c.lidb);
      bus.i_SCR = 1'(c.scr);
      bus.i_L = 5'(c.l);
      bus.i_M = 8'(c.m);
      bus.i_N = 5'(c.n);
      bus.i_CS = 2'(c.cs);
      bus.i_N_ap = 5'(c.nap);
      bus.i_F = 8'(c.f);
      bus.i_K = 5'(c.k);
      bus.i_S = 5'(c.s);
      bus.i_HD = 1'(c.hd);
      bus.i_CF = 5'(c.cf);
      bus.i_ila_mf = 8'(c.mf);
      bus.i_no_frame_de_assertion = 5'(c.nfd);
   endtask

   function automatic cfg_t rand_cfg();
      cfg_t c;
      c.did = $urandom_range(0, 255);
      c.bid = $urandom_range(0, 15);
      c.lidb = $urandom_range(0, 31);
      c.scr = $urandom_range(0, 1);
      c.l = $urandom_range(0, 31);
      c.m = $urandom_range(0, 255);
      c.n = $urandom_range(0, 31);
      c.cs = $urandom_range(0, 3);
      c.nap = $urandom_range(0, 31);
      c.f = $urandom_range(0, 7);
      c.k = $urandom_range(0, 31);
      c.s = $urandom_range(0, 31);
      c.hd = $urandom_range(0, 1);
      c.cf = $urandom_range(0, 31);
      c.mf = $urandom_range(0, 2);
      c.nfd = $urandom_range(0, c.k);
      return c;
   endfunction

   // Expected {k, octet} for one lane at ILA octet index j
   function automatic logic [8:0] exp_oct(input cfg_t c, input int lane,
                                          input int j);
      int fd, kd, per, mfi, p, lid, ph, dir, cnt, sum, v;
      fd = c.f + 1;
      kd = c.k + 1;
      per = fd * kd;
      mfi = j / per;
      p = j % per;
      ph = 0;
      dir = 0;
      cnt = 0;
      if (c.nfd != 0) begin
         ph = 1;
         if (c.nfd <= kd - c.nfd) cnt = c.nfd;
         else begin
            dir = 1;
            cnt = kd - c.nfd;
         end
         if (cnt > 15) cnt = 15;
      end
      lid = (c.lidb + lane) % 32;
      if (p == 0) return 9'h11C;
      if (p == per - 1) return 9'h17C;
      if (mfi == 1 && p == 1) return 9'h19C;
      if (mfi == 1 && p >= 2 && p <= 15) begin
         sum = c.did + c.bid + cnt + lid + ph + dir + c.l + c.scr + c.f
             + c.k + c.m + c.n + c.cs + c.nap + 1 + c.s + 1 + c.cf + c.hd;
         case (p - 2)
            0: v = c.did;
            1: v = cnt * 16 + c.bid;
            2: v = dir * 64 + ph * 32 + lid;
            3: v = c.scr * 128 + c.l;
            4: v = c.f;
            5: v = c.k;
            6: v = c.m;
            7: v = c.cs * 64 + c.n;
            8: v = 32 + c.nap;
            9: v = 32 + c.s;
            10: v = c.hd * 128 + c.cf;
            13: v = sum % 256;
            default: v = 0;
         endcase
         return {1'b0, 8'(v)};
      end
      return {1'b0, 8'(j % 256)};
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_data"}, 64'(bus.o_data), 64'hBCBCBCBC);
      chk({tag, "_k"}, 64'(bus.o_k), 64'hF);
      chk({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
      chk({tag, "_end"}, 64'(bus.o_seq_end), 64'd0);
   endtask

   task automatic run_ila(input cfg_t c, input int abort_at);
      int t;
      logic [8*LANES-1:0] ed;
      logic [LANES-1:0] ek;
      logic [8:0] o;
      bit stop;
      apply(c);
      bus.i_seq_start = 1'b1;
      tick();
      bus.i_seq_start = 1'b0;
      t = (c.mf + 1) * (c.f + 1) * (c.k + 1);
      stop = 1'b0;
      chk("cfg_err_clear", 64'(bus.o_cfg_err), 64'd0);
      for (int j = 0; j < t && !stop; j++) begin
         for (int l = 0; l < LANES; l++) begin
            o = exp_oct(c, l, j);
            ek[l] = o[8];
            ed[8*l +: 8] = o[7:0];
         end
         chk("ila_data", 64'(bus.o_data), 64'(ed));
         chk("ila_k", 64'(bus.o_k), 64'(ek));
         chk("ila_busy", 64'(bus.o_busy), 64'd1);
         chk("ila_end", 64'(bus.o_seq_end), 64'(j == t - 1));
         if (j == 2) apply(rand_cfg());
         if (j == 5 || j == t - 1) bus.i_seq_start = 1'b1;
         if (j == abort_at) begin
            bus.i_abort = 1'b1;
            stop = 1'b1;
         end
         tick();
         bus.i_seq_start = 1'b0;
         bus.i_abort = 1'b0;
      end
      chk_idle("after_ila");
   endtask

   cfg_t base, cx;

   initial begin
      n_assert = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.i_seq_start = 1'b0;
      bus.i_abort = 1'b0;
      base = '{did: 8'h5A, bid: 3, lidb: 0, scr: 1, l: 3, m: 7, n: 15,
               cs: 2, nap: 15, f: 1, k: 15, s: 0, hd: 0, cf: 0, mf: 3,
               nfd: 0};
      apply(base);
      #3;
      chk_idle("reset");
      chk("reset_cfg_err", 64'(bus.o_cfg_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk_idle("post_reset");

      run_ila(base, -1);

      cx = base;
      cx.nfd = 5;
      run_ila(cx, -1);
      cx.nfd = 12;
      run_ila(cx, -1);
      cx.lidb = 30;
      run_ila(cx, -1);

      cx = base;
      cx.f = 0;
      apply(cx);
      bus.i_seq_start = 1'b1;
      tick();
      bus.i_seq_start = 1'b0;
      chk("reject_err", 64'(bus.o_cfg_err), 64'd1);
      chk_idle("reject");
      tick();
      chk("reject_sticky", 64'(bus.o_cfg_err), 64'd1);
      bus.i_seq_start = 1'b1;
      bus.i_abort = 1'b1;
      tick();
      bus.i_seq_start = 1'b0;
      bus.i_abort = 1'b0;
      chk_idle("abort_idle");
      run_ila(base, -1);

      run_ila(base, 39);
      run_ila(base, -1);

      cx = base;
      cx.mf = 0;
      cx.lidb = 7;
      run_ila(cx, -1);

      apply(base);
      bus.i_seq_start = 1'b1;
      tick();
      bus.i_seq_start = 1'b0;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk_idle("async_rst");
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk_idle("after_rst");

      for (int it = 0; it < 10; it++) begin
         cx = rand_cfg();
         if ((cx.f + 1) * (cx.k + 1) < 17) begin
            apply(cx);
            bus.i_seq_start = 1'b1;
            tick();
            bus.i_seq_start = 1'b0;
            chk("rand_reject", 64'(bus.o_cfg_err), 64'd1);
            chk_idle("rand_reject");
         end else begin
            run_ila(cx, -1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ila_generator_ml.md
# ila_generator_ml

Parametrised multi-lane Initial Lane Alignment (ILA) sequence generator for the JESD204B TX link layer. It drives LANES lanes in lockstep, one octet per lane per character clock. It emits the full /R/…/A/ multiframe structure, with /Q/ and the 14-octet link configuration in the second multiframe. LID and FCHK are computed per lane; phase-adjust fields are captured at start, and the sequence can be aborted when SYNC~ re-asserts. It sits between the CGS/SYNC~ controller and the scrambler/8b10b mux, and outputs K28.5 whenever no ILA is in progress.

## Interface
- LANES, 4, number of lanes (1–32)
- clk  in  1  character clock
- rst  in  1  asynchronous, active-high reset
- i_seq_start  in  1  start pulse; sampled only in IDLE
- i_abort  in  1  SYNC~ re-asserted; ends any ILA immediately
- i_no_frame_de_assertion  in  5  frame index within multiframe at SYNC~ de-assertion
- i_ila_mf  in  8  multiframes per ILA, encoded value−1 (0→1 … 255→256)
- i_DID 8, i_BID 4, i_LID_base 5, i_SCR 1, i_L 5, i_M 8, i_N 5, i_CS 2, i_N_ap 5, i_F 8, i_K 5, i_S 5, i_HD 1, i_CF 5  in  link config fields, JESD204B-encoded (value−1 where the standard says so)
- o_data  out  8*LANES  lane n at [8n+7:8n], HGFEDCBA
- o_k  out  LANES  control-character flag per lane
- o_busy  out  1  high while in GEN_ILA
- o_seq_end  out  1  one-cycle pulse coincident with the final /A/
- o_cfg_err  out  1  sticky; set when a start is rejected

## Operation
- Reset: IDLE; o_data every lane 0xBC (K28.5); o_k all 1; o_busy, o_seq_end, o_cfg_err 0; all counters 0.
- States: IDLE, GEN_ILA.
  - IDLE→GEN_ILA: i_seq_start && !i_abort && Fd*Kd ≥ 17, where Fd=i_F+1 and Kd=i_K+1.
  - If i_seq_start arrives with Fd*Kd < 17: stay in IDLE and set o_cfg_err. o_cfg_err clears only on rst or on an accepted start.
  - GEN_ILA→IDLE: after the final octet, or on i_abort.
- Captured at the accepted start; config inputs are not re-sampled during GEN_ILA:
  - All config inputs.
  - Phase adjust from n=i_no_frame_de_assertion:
    - n=0: PHADJ=0, ADJDIR=0, ADJCNT=0.
    - n ≤ Kd−n: PHADJ=1, ADJDIR=0 (advance), ADJCNT=n.
    - Otherwise: PHADJ=1, ADJDIR=1 (delay), ADJCNT=Kd−n.
    - ADJCNT saturates at 15.
- Counters: octet-in-frame 0..Fd−1, frame-in-multiframe 0..Kd−1, multiframe index 0..i_ila_mf, and ramp counter r (8-bit, wraps). All are 0 on the first ILA octet and advance every cycle. Octet-in-multiframe p = frame*Fd + octet.
- Octet selection, identical on all lanes except where noted; first matching rule wins:
  1. p=0 → K28.0 (0x1C), k=1.
  2. p=Fd*Kd−1 → K28.3 (0x7C), k=1.
  3. Multiframe 1, p=1 → K28.4 (0x9C), k=1.
  4. Multiframe 1, p=2..15 → config octet c=p−2, k=0:
     - c=0: DID
     - c=1: {ADJCNT,BID}
     - c=2: {0,ADJDIR,PHADJ,LID}
     - c=3: {SCR,00,L}
     - c=4: F
     - c=5: {000,K}
     - c=6: M
     - c=7: {CS,0,N}
     - c=8: {3'd1 SUBCLASSV,N'}
     - c=9: {3'd1 JESDV,S}
     - c=10: {HD,00,CF}
     - c=11, 12: 0x00
     - c=13: FCHK
  5. Otherwise → r, k=0.
- Per-lane fields: LID = (i_LID_base + n) mod 32. FCHK = sum of all individual field values (DID, BID, ADJCNT, LID, PHADJ, ADJDIR, L, SCR, F, K, M, N, CS, N', SUBCLASSV, S, JESDV, CF, HD) mod 256. FCHK is computed combinationally from captured values and must not use a running accumulator.
- Single-multiframe ILA (i_ila_mf=0): no /Q/ and no config are emitted; rules 3–4 never match.
- i_seq_start while in GEN_ILA is ignored. i_abort in IDLE: no effect, and it wins over a simultaneous start.

## Timing
- Start sampled at edge t → K28.0 on o_data at cycle t+1; o_busy=1 from t+1.
- Total ILA length T=(i_ila_mf+1)*Kd*Fd cycles. Final /A/ and the o_seq_end pulse occur at cycle t+T; K28.5 and o_busy=0 from t+T+1.
- i_abort sampled at edge a → K28.5, o_busy=0 from a+1. No o_seq_end pulse; counters cleared.
- Back-to-back: a start sampled on the cycle o_seq_end is high is ignored, because the state is still GEN_ILA. The earliest accepted start is one cycle later.
- Asynchronous rst mid-ILA: outputs take reset values immediately.

## Test plan
- LANES=4, F=2 (enc 1), K=16 (enc 15), i_ila_mf=3, n=0: 128 octets follow start. /R/ at cycles 1, 33, 65, 97; /A/ at 32, 64, 96, 128; /Q/ at 34; lane 2 octet 37 = 0x02 when LID_base=0; o_seq_end only at cycle 128.
- Same config, n=5, K=16: ADJCNT=5, ADJDIR=0, PHADJ=1. Then n=12: ADJCNT=4, ADJDIR=1. FCHK on each lane equals the field sum mod 256 from the reference model.
- LID_base=30, LANES=4: lane LIDs are 30, 31, 0, 1, and the per-lane FCHK values differ accordingly.
- F=1 (enc 0), K=16 (enc 15): start rejected, o_cfg_err=1, output stays 0xBC. A later valid start is accepted and clears o_cfg_err.
- i_abort at cycle 40 of the ILA: 0xBC from cycle 41, no o_seq_end. A fresh start then replays from K28.0 with r=0.
- i_ila_mf=0: a single multiframe with /R/, ramp data and /A/ only, no /Q/; o_seq_end at cycle Kd*Fd. Random config sweep against the scoreboard.
